// File: rtl/memory_bus.sv
// Bus controller for the F100-L core: decodes RAM, ROM and a small I/O block
// (LEDs, buttons, tick timer) and sequences registered memory reads behind a ready pulse.
module memory_bus #(
  parameter int unsigned TIMER_DIV = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  input  logic        bus_enable,
  input  logic        write_enable,
  output logic        bus_ready,
  output logic [9:0]  ram_address,
  output logic [15:0] ram_data_in,
  input  logic [15:0] ram_data_out,
  output logic        ram_write_enable,
  output logic [9:0]  rom_address,
  input  logic [15:0] rom_data_out,
  output logic [7:0]  leds,
  input  logic [3:0]  buttons
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, READY} state_t;

  state_t                 state_q;
  logic                   ready_q;
  logic [15:0]            data_out_q;
  logic [7:0]             leds_q;
  logic [3:0]             btn_meta_q, btn_sync_q;
  logic [TIMER_DIV-1:0]   prescaler_q, prescaler_d;
  logic [15:0]            timer_q, timer_d;

  logic ram_sel, rom_sel, led_sel, btn_sel, tmr_sel;
  logic idle_req, timer_clr, tick;
  logic [15:0] io_rdata;

  assign ram_sel = (address[15:10] == 6'b000000);
  assign rom_sel = (address[15:10] == 6'b010000);
  assign led_sel = (address == 16'h8000);
  assign btn_sel = (address == 16'h8001);
  assign tmr_sel = (address == 16'h8002);

  assign idle_req  = bus_enable && (state_q == IDLE);
  assign timer_clr = idle_req && write_enable && tmr_sel;

  assign ram_address      = address[9:0];
  assign rom_address      = address[9:0];
  assign ram_data_in      = data_in;
  assign ram_write_enable = reset && idle_req && write_enable && ram_sel;

  assign data_out  = data_out_q;
  assign bus_ready = ready_q;
  assign leds      = leds_q;

  always_comb begin
    io_rdata = '0;
    if (led_sel)      io_rdata = {8'h00, leds_q};
    else if (btn_sel) io_rdata = {12'h000, btn_sync_q};
    else if (tmr_sel) io_rdata = timer_q;
  end

  // The count advances on the edge where the prescaler wraps back to zero.
  always_comb begin
    prescaler_d = prescaler_q + 1'b1;
    tick        = (prescaler_d == '0);
    timer_d     = timer_q;
    if (timer_clr) timer_d = '0;
    else if (tick) timer_d = timer_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler_q <= '0;
      timer_q     <= '0;
      btn_meta_q  <= '0;
      btn_sync_q  <= '0;
    end else begin
      prescaler_q <= prescaler_d;
      timer_q     <= timer_d;
      btn_meta_q  <= buttons;
      btn_sync_q  <= btn_meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      data_out_q <= '0;
      leds_q     <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus_enable) begin
            if (!write_enable && (ram_sel || rom_sel)) begin
              state_q <= WAIT_MEM;
            end else begin
              if (!write_enable) data_out_q <= io_rdata;
              if (write_enable && led_sel) leds_q <= data_in[7:0];
              state_q <= READY;
              ready_q <= 1'b1;
            end
          end
        end
        WAIT_MEM: begin
          data_out_q <= rom_sel ? rom_data_out : ram_data_out;
          state_q    <= READY;
          ready_q    <= 1'b1;
        end
        READY:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_bus.sv
// Directed bench for memory_bus with behavioural registered-read RAM and ROM models.
module tb_memory_bus;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address, data_in, data_out;
  logic        bus_enable, write_enable, bus_ready;
  logic [9:0]  ram_address, rom_address;
  logic [15:0] ram_data_in, ram_data_out, rom_data_out;
  logic        ram_write_enable;
  logic [7:0]  leds;
  logic [3:0]  buttons;

  int checks = 0;
  int errors = 0;

  logic [15:0] ram_mem [0:1023];
  logic [15:0] rom_mem [0:1023];

  always #5 clk = ~clk;

  memory_bus #(.TIMER_DIV(2)) dut (
    .clk(clk), .reset(reset), .address(address), .data_in(data_in),
    .data_out(data_out), .bus_enable(bus_enable), .write_enable(write_enable),
    .bus_ready(bus_ready), .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out), .ram_write_enable(ram_write_enable),
    .rom_address(rom_address), .rom_data_out(rom_data_out),
    .leds(leds), .buttons(buttons)
  );

  always @(posedge clk) begin
    if (ram_write_enable) ram_mem[ram_address] <= ram_data_in;
    else                  ram_data_out <= ram_mem[ram_address];
    rom_data_out <= rom_mem[rom_address];
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic [15:0] a, input logic wr, input logic [15:0] wd,
                        output logic [15:0] rd, output int lat, output int wep);
    @(negedge clk);
    address = a; write_enable = wr; data_in = wd; bus_enable = 1'b1;
    lat = 0; wep = 0;
    while (lat < 8) begin
      #1;
      if (ram_write_enable) wep++;
      @(posedge clk); #1;
      lat++;
      if (bus_ready) break;
    end
    if (!bus_ready) lat = 99;
    rd = data_out;
    bus_enable = 1'b0;
    @(posedge clk);
  endtask

  logic [15:0] rd;
  int lat, wep;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = '0;
      rom_mem[i] = 16'h0100 + 16'(i);
    end
    rom_mem[3] = 16'hBEEF;
    ram_data_out = '0; rom_data_out = '0;

    reset = 1'b0; buttons = 4'b0000;
    address = 16'h0005; data_in = 16'h5555; write_enable = 1'b1; bus_enable = 1'b1;
    #2;
    check("rst_ram_we_forced", {15'b0, ram_write_enable}, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {15'b0, bus_ready}, 16'h0000);
    check("rst_data_out", data_out, 16'h0000);
    check("rst_leds", {8'h00, leds}, 16'h0000);
    bus_enable = 1'b0; write_enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Count read issued on the 40th edge after release: samples 9, next edge holds 10.
    repeat (39) @(posedge clk);
    access(16'h8002, 1'b0, 16'h0000, rd, lat, wep);
    check("timer_40clk_in_range", {15'b0, (rd >= 16'd9 && rd <= 16'd11)}, 16'h0001);
    check("timer_read_lat", 16'(lat), 16'd1);

    access(16'h0005, 1'b1, 16'h1234, rd, lat, wep);
    check("ram_wr_lat", 16'(lat), 16'd1);
    check("ram_wr_strobe_count", 16'(wep), 16'd1);
    #1;
    check("ready_one_cycle", {15'b0, bus_ready}, 16'h0000);
    access(16'h0005, 1'b0, 16'h0000, rd, lat, wep);
    check("ram_rd_data", rd, 16'h1234);
    check("ram_rd_lat", 16'(lat), 16'd2);

    access(16'h4003, 1'b0, 16'h0000, rd, lat, wep);
    check("rom_rd_data", rd, 16'hBEEF);
    check("rom_rd_lat", 16'(lat), 16'd2);
    access(16'h4003, 1'b1, 16'h7777, rd, lat, wep);
    check("rom_wr_lat", 16'(lat), 16'd1);
    check("rom_wr_no_strobe", 16'(wep), 16'd0);
    check("rom_wr_keeps_data_out", rd, 16'hBEEF);
    access(16'h0003, 1'b0, 16'h0000, rd, lat, wep);
    check("ram_untouched_by_rom_wr", rd, 16'h0000);

    access(16'h8000, 1'b1, 16'hA5C3, rd, lat, wep);
    check("led_wr_value", {8'h00, leds}, 16'h00C3);
    check("led_wr_lat", 16'(lat), 16'd1);
    access(16'h8000, 1'b0, 16'h0000, rd, lat, wep);
    check("led_rd_data", rd, 16'h00C3);

    access(16'h2000, 1'b0, 16'h0000, rd, lat, wep);
    check("unmapped_rd_data", rd, 16'h0000);
    check("unmapped_rd_lat", 16'(lat), 16'd1);
    access(16'h4003, 1'b0, 16'h0000, rd, lat, wep);
    access(16'h2000, 1'b1, 16'hFFFF, rd, lat, wep);
    check("unmapped_wr_lat", 16'(lat), 16'd1);
    check("unmapped_wr_no_strobe", 16'(wep), 16'd0);
    check("unmapped_wr_data_out", rd, 16'hBEEF);
    check("unmapped_wr_leds", {8'h00, leds}, 16'h00C3);

    // The earliest possible read-back follows the clear by two edges, so one tick may land.
    access(16'h8002, 1'b1, 16'h0000, rd, lat, wep);
    access(16'h8002, 1'b0, 16'h0000, rd, lat, wep);
    check("timer_clear_readback", {15'b0, (rd <= 16'd1)}, 16'h0001);

    // Four edges after preload always contain exactly one tick.
    @(negedge clk);
    force dut.timer_q = 16'hFFFF;
    @(negedge clk);
    release dut.timer_q;
    repeat (4) @(posedge clk);
    access(16'h8002, 1'b0, 16'h0000, rd, lat, wep);
    check("timer_wrap", rd, 16'h0000);

    #3 buttons = 4'b1010;
    repeat (3) @(posedge clk);
    access(16'h8001, 1'b0, 16'h0000, rd, lat, wep);
    check("buttons_sync_rd", rd, 16'h000A);

    access(16'h4003, 1'b0, 16'h0000, rd, lat, wep);
    @(negedge clk);
    address = 16'h0005; write_enable = 1'b0; bus_enable = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("midrd_rst_data_out", data_out, 16'h0000);
    check("midrd_rst_leds", {8'h00, leds}, 16'h0000);
    begin
      int seen = 0;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        if (bus_ready) seen++;
      end
      check("midrd_rst_no_ready", 16'(seen), 16'd0);
    end
    bus_enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    access(16'h0005, 1'b0, 16'h0000, rd, lat, wep);
    check("post_rst_rd_data", rd, 16'h1234);
    check("post_rst_rd_lat", 16'(lat), 16'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
